// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, buffer entry layout
// and the default buffer depth.
package fetch_pkg;

    localparam int DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundles the PC, instruction-memory and decode-side handshakes of the fetch unit.
// slave is the fetch unit's view; master is the surrounding pipeline/memory.
interface instruction_fetch_if;

    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_err;

    modport slave (
        input  pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output pc_ready, imem_req, imem_addr, instr_valid, instr_out, instr_pc, instr_err
    );

    modport master (
        output pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  pc_ready, imem_req, imem_addr, instr_valid, instr_out, instr_pc, instr_err
    );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular FIFO with synchronous clear and a registered head so the
// decode-side outputs come straight from flops.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  fetch_entry_t                 data_i,
    output logic                         valid_o,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   head_q, head_d;
    logic [PW-1:0]  rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d, rdNext;
    logic [CW-1:0]  count_q, count_d;
    logic           doPush, doPop;

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p);
        wrap = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign doPop   = pop_i && (count_q != '0);
    assign doPush  = push_i && ((count_q != CW'(DEPTH)) || doPop);
    assign rdNext  = wrap(rdPtr_q);

    // The head register tracks whichever entry will sit at the read pointer after this edge.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        head_d  = head_q;
        if (clear_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrap(wrPtr_q);
            if (doPop)  rdPtr_d = rdNext;
            if (doPush && !doPop)      count_d = count_q + 1'b1;
            else if (doPop && !doPush) count_d = count_q - 1'b1;
            if (doPop && (count_q > CW'(1)))           head_d = mem_q[rdNext];
            else if (doPush && ((count_q == '0) || doPop)) head_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !clear_i) mem_q[wrPtr_q] <= data_i;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one outstanding memory access at a time, responses queued
// in a small FIFO toward decode, with flush killing anything already in flight.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    instruction_fetch_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  state_q;
    logic [31:0]   addr_q;
    logic          kill_q;
    logic          imemReq_q;

    logic [CW-1:0] fifoCount;
    logic          fifoValid;
    fetch_entry_t  fifoHead;
    fetch_entry_t  pushEntry;
    logic          accept, aligned, misalignedPush, respPush, push, pop;

    assign aligned        = (bus.pc_in[1:0] == 2'b00);
    assign bus.pc_ready   = (state_q == IDLE) && (fifoCount != CW'(DEPTH)) && !bus.flush;
    assign accept         = bus.pc_valid && bus.pc_ready;
    assign misalignedPush = accept && !aligned;
    assign respPush       = (state_q == WAIT) && bus.imem_rvalid && !kill_q && !bus.flush;
    assign push           = misalignedPush || respPush;
    assign pop            = fifoValid && bus.instr_ready;

    always_comb begin
        pushEntry = '{pc: addr_q, instr: bus.imem_rdata, err: 1'b0};
        if (misalignedPush) pushEntry = '{pc: bus.pc_in, instr: 32'h0, err: 1'b1};
    end

    // A flush never withdraws a pending request; it only marks the response to be dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            kill_q    <= 1'b0;
            imemReq_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && aligned) begin
                        addr_q    <= bus.pc_in;
                        imemReq_q <= 1'b1;
                        kill_q    <= 1'b0;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.flush) kill_q <= 1'b1;
                    if (bus.imem_gnt) begin
                        imemReq_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.flush) kill_q <= 1'b1;
                    if (bus.imem_rvalid) begin
                        kill_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (bus.flush),
        .data_i  (pushEntry),
        .valid_o (fifoValid),
        .head_o  (fifoHead),
        .count_o (fifoCount)
    );

    assign bus.imem_req    = imemReq_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = fifoValid;
    assign bus.instr_out   = fifoHead.instr;
    assign bus.instr_pc    = fifoHead.pc;
    assign bus.instr_err   = fifoHead.err;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected entries into a
// scoreboard queue, an independent monitor pops and compares on every decode handshake.
module tb_instruction_fetch;
    import fetch_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fetch_entry_t exp[$];
    fetch_entry_t monEntry;

    instruction_fetch_if bus();

    instruction_fetch #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every decode handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            if (exp.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_instr: got pc=0x%08h instr=0x%08h err=%0b, required no output",
                         bus.instr_pc, bus.instr_out, bus.instr_err);
            end else begin
                monEntry = exp.pop_front();
                checkOutput("head_pc", bus.instr_pc, monEntry.pc);
                checkOutput("head_instr", bus.instr_out, monEntry.instr);
                checkOutput("head_err", {31'b0, bus.instr_err}, {31'b0, monEntry.err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds pc_valid until accepted; returns one cycle after the accepting edge.
    task automatic acceptPc(input logic [31:0] pc, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        bus.pc_valid = 1'b1;
        bus.pc_in    = pc;
        while (!ok && i < 30) begin
            @(negedge clk);
            if (bus.pc_ready) ok = 1'b1;
            tick();
            i++;
        end
        bus.pc_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: pc 0x%08h got no pc_ready, required pc_ready=1 within 30 cycles", pc);
        end
    endtask

    // Full fetch with immediate grant and next-cycle rvalid; expectation pushed on accept.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] data);
        bit ok;
        acceptPc(pc, ok);
        if (pc[1:0] == 2'b00) begin
            exp.push_back('{pc: pc, instr: data, err: 1'b0});
            bus.imem_gnt = 1'b1;
            @(negedge clk);
            checkOutput("imem_req_after_accept", {31'b0, bus.imem_req}, 32'd1);
            checkOutput("imem_addr", bus.imem_addr, pc);
            tick();
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = data;
            @(negedge clk);
            checkOutput("imem_req_drop", {31'b0, bus.imem_req}, 32'd0);
            tick();
            bus.imem_rvalid = 1'b0;
        end else begin
            exp.push_back('{pc: pc, instr: 32'h0, err: 1'b1});
            @(negedge clk);
            checkOutput("misaligned_no_req", {31'b0, bus.imem_req}, 32'd0);
            tick();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.instr_ready = 1'b1;
        while (exp.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (exp.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: %0d entries still expected, required 0", exp.size());
            exp.delete();
        end
        @(negedge clk);
        checkOutput("empty_after_drain", {31'b0, bus.instr_valid}, 32'd0);
        tick();
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.pc_in       = '0;
        bus.pc_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b1;

        #2;
        checkOutput("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        checkOutput("rst_imem_addr", bus.imem_addr, 32'd0);
        checkOutput("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        checkOutput("rst_instr_out", bus.instr_out, 32'd0);
        checkOutput("rst_instr_pc", bus.instr_pc, 32'd0);
        checkOutput("rst_instr_err", {31'b0, bus.instr_err}, 32'd0);
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("pc_ready_after_reset", {31'b0, bus.pc_ready}, 32'd1);
        tick();

        // Single fetch: instr_valid exactly three cycles after the accept cycle.
        applyStimulus(32'h0000_0100, 32'h0050_0093);
        @(negedge clk);
        checkOutput("single_valid_n3", {31'b0, bus.instr_valid}, 32'd1);
        checkOutput("single_pc_ready", {31'b0, bus.pc_ready}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("single_valid_n4", {31'b0, bus.instr_valid}, 32'd0);
        tick();

        applyStimulus(32'h0000_0102, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("misaligned_still_no_req", {31'b0, bus.imem_req}, 32'd0);
        tick();

        // Backpressure: two entries fill the buffer, third waits for a pop.
        bus.instr_ready = 1'b0;
        applyStimulus(32'h0000_0000, 32'h0000_0013);
        applyStimulus(32'h0000_0004, 32'h00A0_0113);
        bus.pc_valid = 1'b1;
        bus.pc_in    = 32'h0000_0008;
        @(negedge clk);
        checkOutput("full_pc_ready", {31'b0, bus.pc_ready}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("full_pc_ready_hold", {31'b0, bus.pc_ready}, 32'd0);
        checkOutput("full_no_req", {31'b0, bus.imem_req}, 32'd0);
        tick();
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        applyStimulus(32'h0000_0008, 32'h00B0_0193);
        @(negedge clk);
        checkOutput("refull_pc_ready", {31'b0, bus.pc_ready}, 32'd0);
        tick();
        drain();

        // Flush empties a buffered entry and masks pc_ready in the flush cycle.
        bus.instr_ready = 1'b0;
        applyStimulus(32'h0000_0600, 32'h0000_0033);
        bus.flush = 1'b1;
        exp.delete();
        @(negedge clk);
        checkOutput("flush_pc_ready_low", {31'b0, bus.pc_ready}, 32'd0);
        checkOutput("flush_valid_before", {31'b0, bus.instr_valid}, 32'd1);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_empties", {31'b0, bus.instr_valid}, 32'd0);
        tick();
        bus.instr_ready = 1'b1;

        // Flush while in REQ: request stays up until granted, response dropped.
        acceptPc(32'h0000_0500, ok);
        bus.flush = 1'b1;
        @(negedge clk);
        checkOutput("req_held_flush", {31'b0, bus.imem_req}, 32'd1);
        tick();
        bus.flush    = 1'b0;
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        checkOutput("req_no_withdraw", {31'b0, bus.imem_req}, 32'd1);
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_BAD0;
        @(negedge clk);
        checkOutput("req_kill_pc_ready", {31'b0, bus.pc_ready}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("req_kill_no_push", {31'b0, bus.instr_valid}, 32'd0);
        checkOutput("req_kill_ready_back", {31'b0, bus.pc_ready}, 32'd1);
        tick();

        // Flush while in WAIT, then a clean fetch delivered on its own.
        acceptPc(32'h0000_0200, ok);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        bus.flush    = 1'b1;
        @(negedge clk);
        checkOutput("wait_flush_pc_ready", {31'b0, bus.pc_ready}, 32'd0);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        checkOutput("wait_kill_blocks_ready", {31'b0, bus.pc_ready}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("wait_rvalid_pc_ready", {31'b0, bus.pc_ready}, 32'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("wait_kill_ready_back", {31'b0, bus.pc_ready}, 32'd1);
        checkOutput("wait_kill_no_push", {31'b0, bus.instr_valid}, 32'd0);
        tick();
        applyStimulus(32'h0000_0300, 32'h00C0_0213);
        drain();

        // Flush coinciding with rvalid discards that response.
        acceptPc(32'h0000_0400, ok);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1234_5678;
        bus.flush       = 1'b1;
        tick();
        bus.imem_rvalid = 1'b0;
        bus.flush       = 1'b0;
        @(negedge clk);
        checkOutput("flush_rvalid_no_push", {31'b0, bus.instr_valid}, 32'd0);
        checkOutput("flush_rvalid_ready", {31'b0, bus.pc_ready}, 32'd1);
        tick();

        // Async reset mid-REQ with a buffered entry; stray rvalid afterwards ignored.
        bus.instr_ready = 1'b0;
        applyStimulus(32'h0000_0020, 32'h0000_0002);
        acceptPc(32'h0000_0700, ok);
        @(negedge clk);
        checkOutput("mid_req_active", {31'b0, bus.imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        checkOutput("async_rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        checkOutput("async_rst_instr_out", bus.instr_out, 32'd0);
        checkOutput("async_rst_imem_addr", bus.imem_addr, 32'd0);
        exp.delete();
        tick();
        rst_n           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hCAFE_F00D;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_pc_ready", {31'b0, bus.pc_ready}, 32'd1);
        tick();
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("stray_rvalid_ignored", {31'b0, bus.instr_valid}, 32'd0);
        checkOutput("stray_rvalid_no_req", {31'b0, bus.imem_req}, 32'd0);
        tick();

        applyStimulus(32'h0000_0040, 32'h0010_0073);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the fetch-buffer depth in entries (legal 2..8).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pc_in  input  32  fetch address from ProgramCounter PcOut.
REQ-005 pc_valid  input  1  pc_in valid this cycle.
REQ-006 pc_ready  output  1  fetch accepts pc_in; PC SHALL hold when low.
REQ-007 flush  input  1  redirect: discard all queued and in-flight fetches.
REQ-008 imem_req  output  1  memory request, held until imem_gnt.
REQ-009 imem_addr  output  32  memory word address, stable while imem_req.
REQ-010 imem_gnt  input  1  request accepted.
REQ-011 imem_rvalid  input  1  read data valid, at least one cycle after grant.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 instr_valid  output  1  buffer head valid toward decode.
REQ-014 instr_ready  input  1  decode consumes head when high with instr_valid.
REQ-015 instr_out  output  32  instruction word of head.
REQ-016 instr_pc  output  32  address of head.
REQ-017 instr_err  output  1  head is a misaligned-fetch marker; instr_out SHALL be 0.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT; at most one outstanding memory access.
REQ-019 pc_ready SHALL be 1 only in IDLE with buffer count < DEPTH and flush low.
REQ-020 Aligned accept (pc_in[1:0]==0): latch address, go REQ next cycle with imem_req=1, imem_addr=latched address.
REQ-021 REQ: on imem_gnt go WAIT; imem_req SHALL drop in the cycle after grant.
REQ-022 WAIT: on imem_rvalid push {addr, imem_rdata, err=0} into buffer, go IDLE.
REQ-023 Misaligned accept: no memory request; push {pc_in, 0, err=1} next cycle; stay IDLE.
REQ-024 Minimum latency: accept at cycle N, grant N+1, rvalid N+2, instr_valid N+3.
REQ-025 Buffer is FIFO: pop on instr_valid && instr_ready; simultaneous push and pop SHALL keep count unchanged and order intact.
REQ-026 Buffer full: pc_ready=0; the reserved slot guarantees an in-flight response is never dropped.
REQ-027 Empty: instr_valid=0, instr_out/instr_pc/instr_err hold last head or 0 after reset.
REQ-028 flush SHALL empty the buffer at the next edge; pop and push in the flush cycle are ignored.
REQ-029 flush in REQ: imem_req SHALL stay high until grant (no withdrawal); the response is marked kill.
REQ-030 flush in WAIT: response marked kill; a killed response SHALL complete the access and not be pushed.
REQ-031 Flush on the same cycle as imem_rvalid SHALL discard that response.
REQ-032 pc_ready SHALL stay 0 until the killed access completes.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, kill 0, buffer empty, imem_req 0, imem_addr 0, instr_valid 0, instr_out 0, instr_pc 0, instr_err 0.
REQ-034 Reset during REQ/WAIT abandons the access; a stray imem_rvalid after reset SHALL be ignored in IDLE.
REQ-035 pc_ready SHALL be 1 the first cycle after rst_n rises.

Structure
REQ-036 Package fetch_pkg SHALL hold the state enumeration, the buffer entry type {pc, instr, err}, and DEPTH default.
REQ-037 Buffer SHALL be a sub-module fetch_fifo (parameterised depth, push/pop/clear, count, registered head).

Verification
REQ-038 Single fetch: pc_in=0x100, gnt immediate, rvalid next with 0x00500093 -> instr_valid at N+3, instr_pc=0x100, instr_out=0x00500093, err=0.
REQ-039 Backpressure: instr_ready=0, fetch 0x0,0x4,0x8 -> two entries buffered, pc_ready=0, third accepted only after one pop; order 0x0,0x4,0x8.
REQ-040 Misaligned: pc_in=0x102 -> no imem_req, instr_err=1, instr_pc=0x102, instr_out=0.
REQ-041 Flush in WAIT: fetch 0x200, flush before rvalid -> no push, pc_ready=1 cycle after rvalid, next fetch 0x300 delivered alone.
REQ-042 Async reset mid-REQ: rst_n low while imem_req=1 -> imem_req and instr_valid 0 without clock edge; following rvalid ignored.
